// File: rtl/eth_arp_reply_tx.sv
// rtl/eth_arp_reply_tx.sv - ARP reply frame builder emitting one byte per clock
//
// Builds a complete Ethernet II ARP reply (preamble, SFD, headers, ARP payload,
// zero pad, FCS) when a decoded ARP request targets LOCAL_IP.
//
// Ports:
//   clk, rst_n           byte clock, asynchronous active-low reset
//   i_req                one-cycle strobe, ARP request fields valid
//   i_arp_oper/sha/spa/tpa  decoded ARP request fields
//   o_tx_data, o_tx_en   transmit byte stream
//   o_busy               high from accept through end of inter-frame gap
//   o_drop               pulse: request lost because a frame was in progress
//   o_sent               pulse coincident with the last FCS byte
module eth_arp_reply_tx #(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0164,
    parameter int          IFG_LEN   = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_arp_oper,
    input  logic [47:0] i_arp_sha,
    input  logic [31:0] i_arp_spa,
    input  logic [31:0] i_arp_tpa,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_en,
    output logic        o_busy,
    output logic        o_drop,
    output logic        o_sent
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [7:0]  IFG_LAST = 8'(IFG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_BODY, S_PAD, S_FCS, S_IFG
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_crc;
    logic [47:0] r_sha;
    logic [31:0] r_spa;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] v;
        v = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ CRC_POLY) : (v >> 1);
        end
        return v;
    endfunction

    // The 42 header/payload bytes, byte 0 in the top bits.
    logic [335:0] w_body;
    assign w_body = {r_sha, LOCAL_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                     16'h0002, LOCAL_MAC, LOCAL_IP, r_sha, r_spa};

    // Outputs are registered, so the byte chosen here is the one shown next cycle.
    logic [5:0] w_bsel;
    logic [5:0] w_brev;
    logic [7:0] w_body_byte;
    assign w_bsel      = (r_state == S_BODY) ? (r_cnt[5:0] + 6'd1) : 6'd0;
    assign w_brev      = 6'd41 - w_bsel;
    assign w_body_byte = w_body[{w_brev, 3'b000} +: 8];

    // CRC absorbs the byte currently on the wire; FCS byte 0 needs the
    // updated value in the same cycle, later FCS bytes read the frozen register.
    logic [31:0] w_crc_next;
    logic [1:0]  w_fcs_sel;
    logic [7:0]  w_fcs_byte;
    assign w_crc_next = crc32_byte(r_crc, o_tx_data);
    assign w_fcs_sel  = r_cnt[1:0] + 2'd1;
    assign w_fcs_byte = r_crc[{w_fcs_sel, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_crc     <= 32'hFFFFFFFF;
            r_sha     <= 48'd0;
            r_spa     <= 32'd0;
            o_tx_data <= 8'd0;
            o_tx_en   <= 1'b0;
            o_busy    <= 1'b0;
            o_drop    <= 1'b0;
            o_sent    <= 1'b0;
        end else begin
            o_drop <= i_req && o_busy;
            o_sent <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req && (i_arp_oper == 16'h0001) && (i_arp_tpa == LOCAL_IP)) begin
                        r_sha     <= i_arp_sha;
                        r_spa     <= i_arp_spa;
                        r_state   <= S_PRE;
                        r_cnt     <= 8'd0;
                        o_tx_data <= 8'h55;
                        o_tx_en   <= 1'b1;
                        o_busy    <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (r_cnt == 8'd6) begin
                        r_state   <= S_SFD;
                        r_cnt     <= 8'd0;
                        o_tx_data <= 8'hD5;
                    end else begin
                        r_cnt     <= r_cnt + 8'd1;
                        o_tx_data <= 8'h55;
                    end
                end
                S_SFD: begin
                    r_crc     <= 32'hFFFFFFFF;
                    r_state   <= S_BODY;
                    r_cnt     <= 8'd0;
                    o_tx_data <= w_body_byte;
                end
                S_BODY: begin
                    r_crc <= w_crc_next;
                    if (r_cnt == 8'd41) begin
                        r_state   <= S_PAD;
                        r_cnt     <= 8'd0;
                        o_tx_data <= 8'h00;
                    end else begin
                        r_cnt     <= r_cnt + 8'd1;
                        o_tx_data <= w_body_byte;
                    end
                end
                S_PAD: begin
                    r_crc <= w_crc_next;
                    if (r_cnt == 8'd17) begin
                        r_state   <= S_FCS;
                        r_cnt     <= 8'd0;
                        o_tx_data <= ~w_crc_next[7:0];
                    end else begin
                        r_cnt     <= r_cnt + 8'd1;
                        o_tx_data <= 8'h00;
                    end
                end
                S_FCS: begin
                    if (r_cnt == 8'd3) begin
                        r_state   <= S_IFG;
                        r_cnt     <= 8'd0;
                        o_tx_data <= 8'h00;
                        o_tx_en   <= 1'b0;
                    end else begin
                        r_cnt     <= r_cnt + 8'd1;
                        o_tx_data <= ~w_fcs_byte;
                        if (r_cnt == 8'd2) begin
                            o_sent <= 1'b1;
                        end
                    end
                end
                S_IFG: begin
                    if (r_cnt == IFG_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                        o_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                    o_tx_en <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_arp_reply_tx.sv
// tb/tb_eth_arp_reply_tx.sv - self-checking bench for eth_arp_reply_tx
module tb_eth_arp_reply_tx;

    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [31:0] LOCAL_IP  = 32'hC0A8_0164;
    localparam int          IFG_LEN   = 12;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_arp_oper;
    logic [47:0] i_arp_sha;
    logic [31:0] i_arp_spa;
    logic [31:0] i_arp_tpa;
    logic [7:0]  o_tx_data;
    logic        o_tx_en;
    logic        o_busy;
    logic        o_drop;
    logic        o_sent;

    eth_arp_reply_tx #(
        .LOCAL_MAC(LOCAL_MAC),
        .LOCAL_IP (LOCAL_IP),
        .IFG_LEN  (IFG_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_arp_oper(i_arp_oper),
        .i_arp_sha (i_arp_sha),
        .i_arp_spa (i_arp_spa),
        .i_arp_tpa (i_arp_tpa),
        .o_tx_data (o_tx_data),
        .o_tx_en   (o_tx_en),
        .o_busy    (o_busy),
        .o_drop    (o_drop),
        .o_sent    (o_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] crc_tbl [256];
    logic [7:0]  exp_q [$];
    logic [7:0]  cap_q [$];
    int          t_req;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] crc_run(input logic [7:0] q[$], input int lo, input int hi);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = lo; i <= hi; i++) begin
            c = (c >> 8) ^ crc_tbl[(c[7:0] ^ q[i])];
        end
        return c;
    endfunction

    task automatic push_be(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
    endtask

    // Expected wire image of a reply to requester (sha, spa).
    task automatic build_frame(input logic [47:0] sha, input logic [31:0] spa);
        logic [31:0] c;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        push_be({16'h0, sha}, 6);
        push_be({16'h0, LOCAL_MAC}, 6);
        push_be(64'h0806_0001_0800_0604, 8);
        push_be(64'h0002, 2);
        push_be({16'h0, LOCAL_MAC}, 6);
        push_be({32'h0, LOCAL_IP}, 4);
        push_be({16'h0, sha}, 6);
        push_be({32'h0, spa}, 4);
        for (int i = 0; i < 18; i++) exp_q.push_back(8'h00);
        c = ~crc_run(exp_q, 8, 67);
        for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    endtask

    task automatic send_req(input logic [15:0] op, input logic [47:0] sha,
                            input logic [31:0] spa, input logic [31:0] tpa);
        @(negedge clk);
        i_arp_oper = op;
        i_arp_sha  = sha;
        i_arp_spa  = spa;
        i_arp_tpa  = tpa;
        i_req      = 1'b1;
        t_req      = cyc;
        @(negedge clk);
        i_req = 1'b0;
    endtask

    // Collects one burst; optionally injects a second valid request or a reset.
    task automatic capture(input string tag, input int inject_idx, input int rst_idx,
                           output int sent_idx, output int sent_cnt, output int drops,
                           output int t_first, output int t_last);
        int wait_n;
        int len;
        cap_q.delete();
        sent_idx = -1; sent_cnt = 0; drops = 0; t_first = -1; t_last = -1;
        wait_n = 0;
        while (o_tx_en !== 1'b1 && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        if (o_tx_en !== 1'b1) begin
            chk({tag, "_start_timeout"}, 0, 1);
            return;
        end
        t_first = cyc;
        len = 0;
        while (o_tx_en === 1'b1 && len < 100) begin
            i_req = 1'b0;
            cap_q.push_back(o_tx_data);
            t_last = cyc;
            if (o_sent === 1'b1) begin sent_idx = len; sent_cnt++; end
            if (o_drop === 1'b1) drops++;
            if (len == inject_idx) begin
                i_arp_oper = 16'h0001;
                i_arp_sha  = 48'hAA_BB_CC_DD_EE_FF;
                i_arp_spa  = 32'h0A00_0001;
                i_arp_tpa  = LOCAL_IP;
                i_req      = 1'b1;
            end
            if (len == rst_idx) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_rst_tx_en"}, o_tx_en, 0);
                chk({tag, "_rst_busy"}, o_busy, 0);
            end
            len++;
            @(negedge clk);
        end
        i_req = 1'b0;
        if (o_drop === 1'b1) drops++;
    endtask

    task automatic cmp_frame(input string tag, input int sent_idx, input int sent_cnt);
        chk({tag, "_len"}, cap_q.size(), 72);
        if (cap_q.size() == 72) begin
            for (int i = 0; i < 72; i++)
                chk($sformatf("%s_b%0d", tag, i), cap_q[i], exp_q[i]);
            chk({tag, "_residue"}, crc_run(cap_q, 8, 71), 32'hDEBB20E3);
        end
        chk({tag, "_sent_idx"}, sent_idx, 71);
        chk({tag, "_sent_cnt"}, sent_cnt, 1);
    endtask

    task automatic count_busy_tail(output int n);
        n = 0;
        while (o_busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic watch_idle(input int n, output int en_cnt, output int busy_cnt);
        en_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_tx_en !== 1'b0) en_cnt++;
            if (o_busy !== 1'b0) busy_cnt++;
        end
    endtask

    initial begin
        int sidx, scnt, drops, tf1, tl1, tf2, tl2, nbusy, en_c, bz_c;
        logic [63:0] r64;
        logic [47:0] sha;
        logic [31:0] spa, tpa;

        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tbl[n] = c;
        end

        rst_n = 1'b0; i_req = 1'b0;
        i_arp_oper = '0; i_arp_sha = '0; i_arp_spa = '0; i_arp_tpa = '0;
        #1;
        chk("reset_tx_en", o_tx_en, 0);
        chk("reset_tx_data", o_tx_data, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_drop", o_drop, 0);
        chk("reset_sent", o_sent, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed request from the test plan.
        build_frame(48'h11_22_33_44_55_66, 32'hC0A8_0102);
        send_req(16'h0001, 48'h11_22_33_44_55_66, 32'hC0A8_0102, LOCAL_IP);
        chk("latency_tx_en", o_tx_en, 1);
        chk("latency_busy", o_busy, 1);
        capture("dir", -1, -1, sidx, scnt, drops, tf1, tl1);
        cmp_frame("dir", sidx, scnt);
        chk("dir_drops", drops, 0);
        chk("dir_burst_cycles", tl1 - tf1 + 1, 72);
        count_busy_tail(nbusy);
        chk("dir_ifg_busy", nbusy, IFG_LEN);

        // Non-matching requests are ignored silently.
        send_req(16'h0001, 48'h11_22_33_44_55_66, 32'hC0A8_0102, 32'hC0A8_0199);
        watch_idle(100, en_c, bz_c);
        chk("bad_tpa_tx_en", en_c, 0);
        chk("bad_tpa_busy", bz_c, 0);
        send_req(16'h0002, 48'h11_22_33_44_55_66, 32'hC0A8_0102, LOCAL_IP);
        watch_idle(100, en_c, bz_c);
        chk("bad_oper_tx_en", en_c, 0);
        chk("bad_oper_busy", bz_c, 0);
        tpa = $urandom();
        if (tpa == LOCAL_IP) tpa = tpa ^ 32'h1;
        send_req(16'h0001, 48'h1, 32'h2, tpa);
        watch_idle(30, en_c, bz_c);
        chk("rand_tpa_tx_en", en_c, 0);

        // Randomized valid requests.
        for (int k = 0; k < 3; k++) begin
            r64 = {$urandom(), $urandom()};
            sha = r64[47:0];
            spa = $urandom();
            build_frame(sha, spa);
            send_req(16'h0001, sha, spa, LOCAL_IP);
            capture($sformatf("rnd%0d", k), -1, -1, sidx, scnt, drops, tf1, tl1);
            cmp_frame($sformatf("rnd%0d", k), sidx, scnt);
            count_busy_tail(nbusy);
            chk($sformatf("rnd%0d_ifg_busy", k), nbusy, IFG_LEN);
        end

        // Request while busy is dropped; the frame is unaffected.
        build_frame(48'h11_22_33_44_55_66, 32'hC0A8_0102);
        send_req(16'h0001, 48'h11_22_33_44_55_66, 32'hC0A8_0102, LOCAL_IP);
        capture("drop", 29, -1, sidx, scnt, drops, tf1, tl1);
        cmp_frame("drop", sidx, scnt);
        chk("drop_pulses", drops, 1);
        count_busy_tail(nbusy);
        chk("drop_ifg_busy", nbusy, IFG_LEN);
        watch_idle(100, en_c, bz_c);
        chk("drop_no_second_frame", en_c, 0);
        chk("drop_busy_after", bz_c, 0);

        // Two requests 90 cycles apart.
        r64 = {$urandom(), $urandom()};
        sha = r64[47:0];
        spa = $urandom();
        build_frame(sha, spa);
        send_req(16'h0001, sha, spa, LOCAL_IP);
        tf2 = t_req;
        capture("pair1", -1, -1, sidx, scnt, drops, tf1, tl1);
        cmp_frame("pair1", sidx, scnt);
        while (cyc < tf2 + 89) @(negedge clk);
        build_frame(48'h11_22_33_44_55_66, 32'hC0A8_0102);
        send_req(16'h0001, 48'h11_22_33_44_55_66, 32'hC0A8_0102, LOCAL_IP);
        capture("pair2", -1, -1, sidx, scnt, drops, tf2, tl2);
        cmp_frame("pair2", sidx, scnt);
        chk("pair_gap_ok", (tf2 - tl1) >= (IFG_LEN + 1), 1);
        count_busy_tail(nbusy);

        // Reset mid-frame truncates and does not resume.
        send_req(16'h0001, 48'h11_22_33_44_55_66, 32'hC0A8_0102, LOCAL_IP);
        capture("rstf", -1, 19, sidx, scnt, drops, tf1, tl1);
        chk("rstf_truncated_len", cap_q.size(), 20);
        chk("rstf_no_sent", scnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch_idle(40, en_c, bz_c);
        chk("rstf_idle_tx_en", en_c, 0);
        chk("rstf_idle_busy", bz_c, 0);
        spa = $urandom();
        build_frame(48'h11_22_33_44_55_66, spa);
        send_req(16'h0001, 48'h11_22_33_44_55_66, spa, LOCAL_IP);
        capture("post_rst", -1, -1, sidx, scnt, drops, tf1, tl1);
        cmp_frame("post_rst", sidx, scnt);
        count_busy_tail(nbusy);
        chk("post_rst_ifg_busy", nbusy, IFG_LEN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_arp_reply_tx.md
Name: eth_arp_reply_tx

Overview:
Downstream consumer of the receive parser's ARP fields. On a decoded ARP request addressed to the local IP, it builds a complete Ethernet II ARP reply frame. The frame is preamble, SFD, headers, ARP payload, zero pad, then FCS. It is emitted one byte per clock onto the transmit byte stream feeding the MAC/PHY output stage. The FCS is computed internally.

Parameters:
LOCAL_MAC, 48'h02_00_00_00_00_01, station MAC used as frame source and ARP SHA
LOCAL_IP, 32'hC0A8_0164 (192.168.1.100), station IP answered; used as ARP SPA
IFG_LEN, 12, idle clocks enforced after the last FCS byte

Ports:
clk  input  1  byte clock
rst_n  input  1  async active-low reset
i_req  input  1  one-cycle strobe: ARP request fields valid (driven at parser CRC-OK)
i_arp_oper  input  16  ARP OPER field
i_arp_sha  input  48  requester MAC
i_arp_spa  input  32  requester IP
i_arp_tpa  input  32  target IP
o_tx_data  output  8  transmit byte
o_tx_en  output  1  o_tx_data valid this cycle
o_busy  output  1  high from accept through end of IFG
o_drop  output  1  one-cycle pulse: request discarded because busy
o_sent  output  1  one-cycle pulse coincident with last FCS byte

Behaviour:
- Reset (rst_n, asynchronous, active-low; clock clk): state IDLE; o_tx_data=0, o_tx_en=0, o_busy=0, o_drop=0, o_sent=0; CRC register=32'hFFFFFFFF.
- Reset asserted mid-frame: o_tx_en drops immediately (async) and the frame is truncated. No resume after reset release.
- Accept: in IDLE, when i_req=1, i_arp_oper=16'h0001 and i_arp_tpa=LOCAL_IP, latch sha/spa, go to PRE, assert o_busy. Otherwise ignore silently.
- i_req while o_busy=1: o_drop=1 on the next cycle; the request is lost (no queue); the frame in progress is unaffected.
- Latency: first preamble byte has o_tx_en=1 on the cycle after the accepting edge.
- States, with 8-bit byte counter cnt reset to 0 on each transition:
  - PRE: 7 bytes of 8'h55.
  - SFD: 1 byte of 8'hD5; CRC reg initialised to FFFFFFFF here.
  - BODY: 42 bytes, index 0..41, in order:
    - dst MAC = latched sha, MSB byte first (6)
    - src MAC = LOCAL_MAC (6)
    - type 08 06
    - HTYPE 00 01
    - PTYPE 08 00
    - HLEN 06
    - PLEN 04
    - OPER 00 02
    - SHA = LOCAL_MAC (6)
    - SPA = LOCAL_IP (4)
    - THA = latched sha (6)
    - TPA = latched spa (4)
  - PAD: 18 bytes of 8'h00, bringing the frame to 60 bytes before FCS.
  - FCS: 4 bytes = ~crc, least significant byte first (crc[7:0] first).
  - IFG: IFG_LEN clocks with o_tx_en=0; then IDLE, where o_busy falls.
- o_tx_en is continuous (no gaps) from the first preamble byte through the last FCS byte: 72 consecutive cycles.
- CRC: IEEE 802.3 reflected CRC-32, polynomial 0xEDB88320, init FFFFFFFF, byte-wise LSB-first. It updates on every BODY and PAD byte (60 bytes) and is frozen during FCS. Its output must match calc_crc32 in the receive path bit-for-bit.
- Widths: all header fields are fixed-width selects from latched registers; there is no arithmetic other than cnt+1 (8 bits, never exceeds 41) and CRC.
- A new i_req arriving on the same cycle the FSM returns to IDLE is not accepted; i_req is sampled only while in IDLE with o_busy=0.

Test Plan:
- Valid request (oper=0001, sha=11:22:33:44:55:66, spa=C0A80102, tpa=LOCAL_IP) -> 72-byte burst: 7x55, D5, 11 22 33 44 55 66, 02 00 00 00 00 01, 08 06 00 01 08 00 06 04 00 02, LOCAL_MAC, C0 A8 01 64, 11..66, C0 A8 01 02, 18x00, 4 FCS bytes. o_sent is high on byte 72.
- FCS check: a reference CRC run over 60 body+pad bytes plus the 4 FCS bytes leaves register 32'hDEBB20E3. Looped into the receive parser, it reaches its CRC-OK state.
- tpa=C0A80199, or oper=0002 -> o_tx_en stays 0; o_busy stays 0 for 100 cycles.
- Second valid i_req at byte 30 of a frame -> o_drop pulses once; the frame is unchanged. After IFG, o_busy=0 and no second frame is sent.
- Two requests spaced 90 cycles apart -> two identical-format frames; gap between last FCS byte and next preamble is at least IFG_LEN+1 cycles.
- rst_n low at byte 20 of a frame -> o_tx_en=0 and o_busy=0 at once. After release, idle until a new valid i_req, then a full 72-byte frame is sent.
